// File: rtl/proc_req_queue_if.sv
// Processor request / segregator handshake bundle for proc_req_queue.
// master = processor plus cache controller side, slave = the queue itself.
interface proc_req_queue_if #(
    parameter int ADDR_WID = 32,
    parameter int PTR_WID  = 2
);
    logic                proc_rd;
    logic                proc_wr;
    logic [ADDR_WID-1:0] proc_addr;
    logic                proc_stall;
    logic                err_illegal;
    logic                cmd_rd;
    logic                cmd_wr;
    logic [ADDR_WID-1:0] address;
    logic                cmd_done;
    logic [PTR_WID:0]    count;

    modport master (
        output proc_rd, proc_wr, proc_addr, cmd_done,
        input  proc_stall, err_illegal, cmd_rd, cmd_wr, address, count
    );

    modport slave (
        input  proc_rd, proc_wr, proc_addr, cmd_done,
        output proc_stall, err_illegal, cmd_rd, cmd_wr, address, count
    );
endinterface

// File: rtl/proc_req_queue.sv
// In-order processor request FIFO feeding the cache address segregator.
// Optional PROC_REQ_QUEUE_STATS_EN adds saturating accepted-read/write counters.
module proc_req_queue #(
    parameter int ADDR_WID = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_WID  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    proc_req_queue_if.slave   bus
`ifdef PROC_REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]       rd_accepted,
    output logic [15:0]       wr_accepted
`endif
);
    localparam logic [PTR_WID:0]   FULL_CNT = (PTR_WID+1)'(DEPTH);
    localparam logic [PTR_WID:0]   CNT_ONE  = (PTR_WID+1)'(1);
    localparam logic [PTR_WID-1:0] PTR_ONE  = PTR_WID'(1);

    // Entry layout: {is_wr, addr}
    logic [ADDR_WID:0]   mem [DEPTH];
    logic [PTR_WID-1:0]  wr_ptr;
    logic [PTR_WID-1:0]  rd_ptr;
    logic [PTR_WID:0]    count;
    logic [ADDR_WID-1:0] addr_hold;
    logic                err;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [ADDR_WID:0] head;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = (bus.proc_rd ^ bus.proc_wr) & ~full;
    assign pop   = bus.cmd_done & ~empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            addr_hold <= '0;
            err       <= 1'b0;
        end else begin
            err <= bus.proc_rd & bus.proc_wr;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // Remember what is on the bus so address stays put once the queue drains
            if (!empty)
                addr_hold <= head[ADDR_WID-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.proc_wr, bus.proc_addr};
    end

    assign bus.proc_stall  = full;
    assign bus.err_illegal = err;
    assign bus.count       = count;
    assign bus.cmd_rd      = ~empty & ~head[ADDR_WID];
    assign bus.cmd_wr      = ~empty &  head[ADDR_WID];
    assign bus.address     = empty ? addr_hold : head[ADDR_WID-1:0];

`ifdef PROC_REQ_QUEUE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_accepted <= '0;
            wr_accepted <= '0;
        end else if (push) begin
            if (bus.proc_wr)
                wr_accepted <= sat_inc(wr_accepted);
            else
                rd_accepted <= sat_inc(rd_accepted);
        end
    end
`endif
endmodule
